sar_search: RTL and testbench

//  Successive-approximation search controller: drives the 'a' operand of an external

---
 rtl/sar_search_pkg.sv | 15 +
 rtl/sar_search.sv | 100 ++++++++++
 tb/tb_sar_search.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
// Shared types for the successive-approximation search controller.
// State encodings are 2-bit; a small helper checks that the comparator flags are one-hot.
package sar_search_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TEST = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic flags_one_hot(input logic gt, input logic lt, input logic eq);
    return ({gt, lt, eq} == 3'b100) || ({gt, lt, eq} == 3'b010) || ({gt, lt, eq} == 3'b001);
  endfunction

endpackage

// File: rtl/sar_search.sv
// MSB-first successive-approximation search against an external combinational comparator.
// Define SAR_EARLY_EXIT_EN to finish as soon as the comparator reports equality.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] trial,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             exact,
  output logic             err
);

  localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exact_q, exact_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] kept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      trial_q  <= '0;
      mask_q   <= '0;
      result_q <= '0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    mask_d   = mask_q;
    result_d = result_q;
    exact_d  = exact_q;
    err_d    = err_q;
    // Only cmp_gt decides the bit under test; malformed flags are recorded, never acted on.
    kept     = cmp_gt ? (trial_q & ~mask_q) : trial_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_TEST;
          trial_d = TOP_BIT;
          mask_d  = TOP_BIT;
          exact_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_TEST: begin
        exact_d = exact_q | cmp_eq;
        err_d   = err_q | !flags_one_hot(cmp_gt, cmp_lt, cmp_eq);
`ifdef SAR_EARLY_EXIT_EN
        if (cmp_eq) begin
          result_d = trial_q;
          exact_d  = 1'b1;
          state_d  = ST_DONE;
        end else
`endif
        if (mask_q[0]) begin
          trial_d  = kept;
          result_d = kept;
          state_d  = ST_DONE;
        end else begin
          mask_d  = mask_q >> 1;
          trial_d = kept | (mask_q >> 1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign trial  = trial_q;
  assign result = result_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign exact  = exact_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: behavioural comparator, expected-trial scoreboard, summary line.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cmp_gt, cmp_lt, cmp_eq;
  logic [3:0] trial, result;
  logic       busy, done, exact, err;
  logic [3:0] target = 4'd0;
  logic       force_bad = 1'b0;

  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Comparator model; force_bad drives the illegal gt+lt combination.
  always_comb begin
    cmp_gt = force_bad ? 1'b1 : (trial > target);
    cmp_lt = force_bad ? 1'b1 : (trial < target);
    cmp_eq = force_bad ? 1'b0 : (trial == target);
  end

  sar_search #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .trial  (trial),
    .result (result),
    .busy   (busy),
    .done   (done),
    .exact  (exact),
    .err    (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_trials(input int n, input logic [3:0] a, b, c, d);
    logic [3:0] v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < n; i++) exp_q.push_back(32'(v[i]));
  endtask

  // Launches one search from a negedge in IDLE; cycle k is the period following edge k-1.
  task automatic do_search(input logic [3:0] tgt, input int exp_done, input logic [3:0] exp_res,
                           input logic exp_exact, input logic exp_err,
                           input int bad_cyc, input int poke_cyc);
    int cyc;
    bit seen;
    target = tgt;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    seen  = 1'b0;
    while (!seen && cyc <= 20) begin
      force_bad = (cyc == bad_cyc);
      start     = (cyc == poke_cyc);
      if (done) begin
        seen = 1'b1;
        check("done_cycle", cyc, exp_done);
        check("busy_in_done", busy, 1);
      end else begin
        check("trial", trial, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
        check("busy_in_test", busy, 1);
        @(negedge clk);
        cyc++;
      end
    end
    force_bad = 1'b0;
    start     = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    check("result", result, exp_res);
    check("exact", exact, exp_exact);
    check("err", err, exp_err);
    check("trials_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("busy_after", busy, 0);
    check("done_pulse", done, 0);
    check("result_hold", result, exp_res);
  endtask

  initial begin
    int first_done, second_done;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_trial", trial, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_exact", exact, 0);
    check("rst_err", err, 0);

    push_trials(4, 8, 12, 10, 9);
    do_search(4'd9, 5, 4'd9, 1, 0, 0, 0);
    push_trials(4, 8, 4, 2, 1);
    do_search(4'd0, 5, 4'd0, 0, 0, 0, 0);
    push_trials(4, 8, 12, 14, 15);
    do_search(4'd15, 5, 4'd15, 1, 0, 0, 0);
    push_trials(4, 8, 4, 6, 5);
    do_search(4'd5, 5, 4'd5, 1, 0, 0, 0);
`ifdef SAR_EARLY_EXIT_EN
    push_trials(1, 8, 0, 0, 0);
    do_search(4'd8, 2, 4'd8, 1, 0, 0, 0);
    push_trials(2, 8, 12, 0, 0);
    do_search(4'd12, 3, 4'd12, 1, 0, 0, 0);
`else
    push_trials(4, 8, 12, 10, 9);
    do_search(4'd8, 5, 4'd8, 1, 0, 0, 0);
    push_trials(4, 8, 12, 14, 13);
    do_search(4'd12, 5, 4'd12, 1, 0, 0, 0);
`endif
    // Illegal flags in step 2 set err without disturbing the path.
    push_trials(4, 8, 12, 10, 9);
    do_search(4'd9, 5, 4'd9, 1, 1, 2, 0);
    // start pulsed mid-search is ignored.
    push_trials(4, 8, 12, 10, 9);
    do_search(4'd9, 5, 4'd9, 1, 0, 0, 2);

    // Reset in TEST step 2 clears everything, including the held result.
    target = 4'd3;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_trial", trial, 0);
    check("midrst_result", result, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_exact", exact, 0);
    check("midrst_err", err, 0);
    push_trials(4, 8, 4, 2, 3);
    do_search(4'd3, 5, 4'd3, 1, 0, 0, 0);

    // start held high: accepted every 6 cycles.
    target      = 4'd6;
    first_done  = 0;
    second_done = 0;
    start       = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 12) start = 1'b0;
      if (cyc == 6) check("held_gap_busy", busy, 0);
      if (done && first_done == 0) first_done = cyc;
      else if (done && second_done == 0) second_done = cyc;
    end
    check("held_first_done", first_done, 5);
    check("held_second_done", second_done, 11);
    check("held_result", result, 6);
    repeat (2) @(negedge clk);
    check("held_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
